instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage that supplies the instruction decoder: it owns the PC, issues one instruction-memory read at a time, and presents each fetched 16-bit instruction with its PC+2 over a valid/ready handshake. It stops fetching after delivering a HALT (opcode 5'b00000). It squashes in-flight or pending instructions on a redirect from execute (branch or jump).

## Interface
- RESET_PC, 16'h0000: PC loaded at reset.
- NOP_INSTR, 16'h0800: value of id_instr while nothing valid is presented (opcode 5'b00001).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request. Held high until imem_done.
- imem_addr  out  16  read address, equal to the current PC. Stable while imem_req is high and imem_done is low.
- imem_done  in  1  read complete; imem_rdata is valid this cycle. Asserted no earlier than the cycle after imem_req rises.
- imem_rdata  in  16  instruction word.
- id_valid  out  1  id_instr/id_pc_plus2 hold a live instruction.
- id_ready  in  1  decoder accepts this cycle; a transfer occurs when id_valid & id_ready.
- id_instr  out  16  instruction to the decoder.
- id_pc_plus2  out  16  address of the fetched instruction + 2.
- redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc.
- redirect_pc  in  16  new PC, word-aligned (bit 0 ignored, treated as 0).
- halted  out  1  HALT has been accepted by the decoder. Sticky until reset.

## Operation
- State machine states: FETCH, DELIVER, HALT, STOPPED.
- State register holds a flush flag in addition to the state.
- **Reset values.**
  - State FETCH; pc = RESET_PC; flush = 0.
  - imem_req = 0 while rst_n is low.
  - id_valid = 0; id_instr = NOP_INSTR; id_pc_plus2 = 0; halted = 0.
- **FETCH**
  - Drives imem_req = 1 and imem_addr = pc.
  - On imem_done with flush = 0 and no redirect:
    - Load id_instr = imem_rdata, id_pc_plus2 = pc + 2, id_valid = 1.
    - Set pc <= pc + 2.
    - Next state is HALT if imem_rdata[15:11] == 5'b00000, else DELIVER.
  - On imem_done with flush = 1: discard the data, clear flush, remain in FETCH. The next request uses the redirect target.
- **DELIVER**
  - imem_req = 0; id_valid = 1.
  - On id_ready: next cycle id_valid = 0, id_instr = NOP_INSTR, state FETCH.
- **HALT**
  - Same as DELIVER, except on id_ready: id_valid = 0, halted = 1, state STOPPED.
- **STOPPED**
  - imem_req = 0; id_valid = 0.
  - All inputs are ignored, including redirect.
- **Redirect**, in FETCH, DELIVER or HALT:
  - Set pc <= {redirect_pc[15:1], 1'b0}; id_valid <= 0; id_instr <= NOP_INSTR; next state FETCH.
  - If a request is outstanding (FETCH, imem_req high, imem_done low), set flush = 1 and keep imem_addr at the old PC until imem_done.
  - Redirect in the same cycle as imem_done: data is dropped, flush stays 0, and the next cycle issues a request at the new PC.
  - Redirect in the same cycle as id_ready in DELIVER/HALT: the transfer completes (the decoder took it), then the flush takes effect. A HALT squashed by redirect never sets halted.
- **Arithmetic.** PC arithmetic is 16-bit modulo; 16'hFFFE + 2 wraps to 16'h0000.

## Timing
- imem_req and imem_addr are decoded from registered state and pc only. No combinational path exists from any input to any output.
- imem_done in cycle t: id_valid high from cycle t+1.
- id_ready in cycle t (DELIVER): imem_req high in cycle t+1.
- Throughput: one instruction per (memory latency + 1 + decode stall) cycles; at most one request outstanding.
- Redirect in cycle t with no outstanding request: imem_addr = redirect_pc in cycle t+1.
- Reset asserted mid-request: outputs return to reset values immediately. The memory must tolerate an abandoned request.

## Structure
- Shared package (used with the decoder):
  - opcode constants OP_HALT = 5'b00000 and OP_NOP = 5'b00001;
  - NOP_INSTR default value;
  - fetch state encoding.
- One sub-module, fetch_pc_reg: 16-bit PC register with async active-low reset to RESET_PC, an increment-by-2 enable, and a load enable. Load has priority over increment.

## Test plan
- **Reset and first fetch.** Reset, release, memory done after 2 cycles with 16'h4123. Expected:
  - imem_addr 0;
  - id_valid with id_instr 16'h4123 and id_pc_plus2 16'h0002;
  - next imem_addr 16'h0002 after id_ready.
- **Decode stall.** Hold id_ready low 5 cycles. Expected: id_valid and id_instr stable; imem_req low throughout; pc unchanged.
- **Redirect during outstanding request.** At addr 16'h0010, pulse redirect with 16'h0100 before imem_done. Expected:
  - returned word is discarded and id_valid stays 0;
  - imem_addr 16'h0010 held until done;
  - next request at 16'h0100.
- **HALT delivery.** Fetch 16'h0000, accept it. Expected:
  - halted rises the cycle after acceptance;
  - imem_req never reasserts;
  - a later redirect is ignored.
- **HALT squashed.** Fetch 16'h0000, pulse redirect to 16'h0020 before id_ready. Expected: halted stays 0; fetch resumes at 16'h0020.
- **Wrap and async reset.** Start at pc 16'hFFFE: next address 16'h0000. Drop rst_n mid-cycle while imem_req is high: imem_req, id_valid and halted go to 0 without a clock edge.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: opcodes, the idle instruction word and the
// fetch state encoding.
package instr_fetch_pkg;

  localparam int          DATA_W    = 16;
  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [4:0]  OP_NOP    = 5'b00001;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DELIVER = 2'd1,
    HALT    = 2'd2,
    STOPPED = 2'd3
  } fetch_state_t;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: async reset to RESET_PC, increment by 2, load with priority.
module fetch_pc_reg
  import instr_fetch_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_val,
  output logic [DATA_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC[DATA_W-1:0];
    end else if (ld) begin
      pc <= ld_val;
    end else if (inc) begin
      pc <= pc + DATA_W'(2);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem read, valid/ready delivery to
// the decoder, HALT stop and redirect squash.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc_plus2,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  fetch_state_t state_q, state_d;
  logic         flush_q, flush_d;
  logic         run_q;
  logic [15:0]  pc;
  logic [15:0]  pc_plus2;
  logic [15:0]  target;
  logic [15:0]  hold_addr_q;
  logic         pc_inc, pc_ld, hold_ld;
  logic         capture, clear_out, set_halted;
  logic         outstanding;
  logic         vld_p1;
  logic [15:0]  id_instr_p1;
  logic [15:0]  id_pc_plus2_p1;
  logic         halted_q;

  fetch_pc_reg #(.DATA_W(DATA_W)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (pc_inc),
    .ld     (pc_ld),
    .ld_val (target),
    .pc     (pc)
  );

  assign pc_plus2    = pc + 16'd2;
  assign target      = redirect_pc & 16'hFFFE;
  // run_q keeps imem_req low through reset without sampling rst_n combinationally
  assign imem_req    = run_q && (state_q == FETCH);
  assign imem_addr   = flush_q ? hold_addr_q : pc;
  assign outstanding = imem_req && !imem_done;

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    hold_ld    = 1'b0;
    capture    = 1'b0;
    clear_out  = 1'b0;
    set_halted = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_ld   = 1'b1;
          flush_d = outstanding;
          // keep presenting the address the memory is still working on
          hold_ld = outstanding && !flush_q;
        end else if (imem_req && imem_done) begin
          if (flush_q) begin
            flush_d = 1'b0;
          end else begin
            capture = 1'b1;
            pc_inc  = 1'b1;
            state_d = is_halt(imem_rdata) ? HALT : DELIVER;
          end
        end
      end
      DELIVER, HALT: begin
        if (redirect) begin
          pc_ld     = 1'b1;
          clear_out = 1'b1;
          state_d   = FETCH;
        end else if (id_ready) begin
          clear_out = 1'b1;
          if (state_q == HALT) begin
            set_halted = 1'b1;
            state_d    = STOPPED;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      flush_q  <= 1'b0;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      run_q    <= 1'b1;
      halted_q <= halted_q | set_halted;
    end
  end

  always_ff @(posedge clk) begin
    if (hold_ld) hold_addr_q <= pc;
  end

  // stage p1: instruction presented to the decoder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1         <= 1'b0;
      id_instr_p1    <= NOP_INSTR;
      id_pc_plus2_p1 <= 16'h0000;
    end else if (capture) begin
      vld_p1         <= 1'b1;
      id_instr_p1    <= imem_rdata;
      id_pc_plus2_p1 <= pc_plus2;
    end else if (clear_out) begin
      vld_p1         <= 1'b0;
      id_instr_p1    <= NOP_INSTR;
    end
  end

  assign id_valid    = vld_p1;
  assign id_instr    = id_instr_p1;
  assign id_pc_plus2 = id_pc_plus2_p1;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, fetch/deliver, stall, redirects,
// HALT handling, PC wrap and asynchronous reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [15:0] id_pc_plus2;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  int passed = 0;
  int total  = 0;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_done   (imem_done),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc_plus2 (id_pc_plus2),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_done = 1'b0; imem_rdata = 16'h0000;
    id_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

    // reset state
    cyc(); cyc();
    chk("rst_req",    16'(imem_req),  16'h0000);
    chk("rst_valid",  16'(id_valid),  16'h0000);
    chk("rst_instr",  id_instr,       16'h0800);
    chk("rst_pc2",    id_pc_plus2,    16'h0000);
    chk("rst_halted", 16'(halted),    16'h0000);
    rst_n = 1'b1;

    // first fetch
    cyc();
    chk("f1_req",  16'(imem_req), 16'h0001);
    chk("f1_addr", imem_addr,     16'h0000);
    cyc();
    imem_done = 1'b1; imem_rdata = 16'h4123;
    cyc();
    imem_done = 1'b0;
    chk("f1_valid", 16'(id_valid), 16'h0001);
    chk("f1_instr", id_instr,      16'h4123);
    chk("f1_pc2",   id_pc_plus2,   16'h0002);

    // decode stall
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_valid", 16'(id_valid), 16'h0001);
      chk("stall_instr", id_instr,      16'h4123);
      chk("stall_req",   16'(imem_req), 16'h0000);
    end
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    chk("acc_valid", 16'(id_valid), 16'h0000);
    chk("acc_instr", id_instr,      16'h0800);
    chk("acc_req",   16'(imem_req), 16'h0001);
    chk("acc_addr",  imem_addr,     16'h0002);

    // second fetch, then redirect while delivering (odd target rounds down)
    cyc();
    imem_done = 1'b1; imem_rdata = 16'h0810;
    cyc();
    imem_done = 1'b0;
    chk("f2_instr", id_instr,    16'h0810);
    chk("f2_pc2",   id_pc_plus2, 16'h0004);
    redirect = 1'b1; redirect_pc = 16'h0011;
    cyc();
    redirect = 1'b0;
    chk("rd1_valid", 16'(id_valid), 16'h0000);
    chk("rd1_instr", id_instr,      16'h0800);
    chk("rd1_req",   16'(imem_req), 16'h0001);
    chk("rd1_addr",  imem_addr,     16'h0010);

    // redirect with a request outstanding at 0x0010
    cyc();
    redirect = 1'b1; redirect_pc = 16'h0100;
    cyc();
    redirect = 1'b0;
    chk("fl_addr_a", imem_addr,     16'h0010);
    chk("fl_req",    16'(imem_req), 16'h0001);
    cyc();
    chk("fl_addr_b", imem_addr,     16'h0010);
    imem_done = 1'b1; imem_rdata = 16'h4444;
    cyc();
    imem_done = 1'b0;
    chk("fl_valid", 16'(id_valid), 16'h0000);
    chk("fl_req2",  16'(imem_req), 16'h0001);
    chk("fl_addr2", imem_addr,     16'h0100);

    // HALT squashed by redirect
    cyc();
    chk("hs_valid0", 16'(id_valid), 16'h0000);
    imem_done = 1'b1; imem_rdata = 16'h0000;
    cyc();
    imem_done = 1'b0;
    chk("hs_valid", 16'(id_valid), 16'h0001);
    chk("hs_instr", id_instr,      16'h0000);
    chk("hs_pc2",   id_pc_plus2,   16'h0102);
    chk("hs_req",   16'(imem_req), 16'h0000);
    redirect = 1'b1; redirect_pc = 16'h0020;
    cyc();
    redirect = 1'b0;
    chk("hs_halted", 16'(halted),   16'h0000);
    chk("hs_valid2", 16'(id_valid), 16'h0000);
    chk("hs_req2",   16'(imem_req), 16'h0001);
    chk("hs_addr",   imem_addr,     16'h0020);

    // HALT delivered
    cyc();
    imem_done = 1'b1; imem_rdata = 16'h0000;
    cyc();
    imem_done = 1'b0;
    chk("h_pc2",    id_pc_plus2,  16'h0022);
    chk("h_halt0",  16'(halted),  16'h0000);
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    chk("h_halted", 16'(halted),   16'h0001);
    chk("h_valid",  16'(id_valid), 16'h0000);
    chk("h_req",    16'(imem_req), 16'h0000);
    redirect = 1'b1; redirect_pc = 16'h0200;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("st_req",    16'(imem_req), 16'h0000);
      chk("st_valid",  16'(id_valid), 16'h0000);
      chk("st_halted", 16'(halted),   16'h0001);
    end

    // reset while stopped, redirect to 0xFFFE, wrap
    rst_n = 1'b0;
    #1;
    chk("r2_halted", 16'(halted), 16'h0000);
    cyc();
    rst_n = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    cyc();
    redirect = 1'b0;
    chk("w_req",  16'(imem_req), 16'h0001);
    chk("w_addr", imem_addr,     16'hFFFE);
    cyc();
    imem_done = 1'b1; imem_rdata = 16'h1234;
    cyc();
    imem_done = 1'b0;
    chk("w_valid", 16'(id_valid), 16'h0001);
    chk("w_pc2",   id_pc_plus2,   16'h0000);
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    chk("w_addr2", imem_addr,     16'h0000);
    chk("w_req2",  16'(imem_req), 16'h0001);

    // asynchronous reset mid-cycle with a request outstanding
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req",    16'(imem_req), 16'h0000);
    chk("ar_valid",  16'(id_valid), 16'h0000);
    chk("ar_halted", 16'(halted),   16'h0000);
    chk("ar_instr",  id_instr,      16'h0800);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
